// File: rtl/array_mul_sched.sv
// array_mul_sched: two-requester round-robin scheduler for a
// registered N-bit array multiplier with a shared operand bus.
module array_mul_sched #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*N-1:0]   req_data,
  output logic [N-1:0]     mul_data,
  output logic             mul_load_a,
  output logic             mul_load_b,
  input  logic [2*N-1:0]   mul_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_product,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_A,
    S_LD_B,
    S_WAIT,
    S_RES
  } state_t;

  state_t           r_state;
  logic             r_grant;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  logic             w_pick;
  logic             w_gvalid;
  logic [N-1:0]     w_gdata;
  logic             w_ld_a;
  logic             w_ld_b;
  logic             w_ld;
  logic             w_res;

  assign w_ld_a = (r_state == S_LD_A);
  assign w_ld_b = (r_state == S_LD_B);
  assign w_ld   = w_ld_a | w_ld_b;
  assign w_res  = (r_state == S_RES);

  // Round-robin pick: on a tie the requester that was not
  // served last wins; otherwise whichever one is asking.
  assign w_pick = (&req_valid) ? ~r_last : req_valid[1];

  assign w_gvalid = r_grant ? req_valid[1] : req_valid[0];
  assign w_gdata  = r_grant ? req_data[2*N-1:N]
                            : req_data[N-1:0];

  // Scheduler FSM: grant, two operand beats, one cycle for
  // the product register, then hold the result until taken.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_grant <= w_pick;
            r_state <= S_LD_A;
          end
        end
        S_LD_A: begin
          if (w_gvalid) r_state <= S_LD_B;
        end
        S_LD_B: begin
          if (w_gvalid) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_state <= S_RES;
        end
        S_RES: begin
          if (res_ready) begin
            r_last  <= r_grant;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus, handshake and result outputs decoded from state;
  // nothing here looks at res_ready.
  always_comb begin
    req_ready   = 2'b00;
    mul_data    = '0;
    mul_load_a  = 1'b0;
    mul_load_b  = 1'b0;
    res_valid   = 1'b0;
    res_product = '0;
    res_id      = 1'b0;
    if (w_ld) begin
      req_ready  = r_grant ? 2'b10 : 2'b01;
      mul_data   = w_gdata;
      mul_load_a = w_ld_a & w_gvalid;
      mul_load_b = w_ld_b & w_gvalid;
    end
    if (w_res) begin
      res_valid   = 1'b1;
      res_product = mul_product;
      res_id      = r_grant;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign op_count = r_cnt;

endmodule

// File: doc/array_mul_sched.md
# array_mul_sched

Two-requester scheduler for the registered N-bit array multiplier, whose interface is a shared N-bit operand bus, `load_a`/`load_b` strobes and a registered 2N-bit product.
- Arbitrates between two operand sources round-robin.
- Serialises each source's A-then-B operand beats onto the shared bus.
- Waits out the multiplier's output-register latency.
- Returns the product on a single valid/ready result port, tagged with the requester id.
- Sits between the requesting engines and the multiplier instance; the multiplier shares this block's clock and reset.

## Interface
- `N`, 8, operand width; must match the multiplier instance.
- `CNT_W`, 16, width of the completed-operation counter.

- `clk`  in  1  single clock, rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester beat valid.
- `req_ready`  out  2  per-requester beat accept.
- `req_data`  in  2*N  requester i operand at `[i*N +: N]`; beat 1 = A, beat 2 = B.
- `mul_data`  out  N  shared operand bus to the multiplier.
- `mul_load_a`  out  1  load strobe for multiplier register A.
- `mul_load_b`  out  1  load strobe for multiplier register B.
- `mul_product`  in  2*N  registered multiplier product.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accept.
- `res_product`  out  2*N  result value.
- `res_id`  out  1  requester that owns the result.
- `busy`  out  1  high whenever state is not IDLE.
- `op_count`  out  CNT_W  results accepted since reset; wraps modulo 2^CNT_W.

## Operation
- **States:** IDLE, LD_A, LD_B, WAIT, RES. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` is high, latch `grant` and go to LD_A.
  - If both are high, grant the requester != `last_grant`.
  - If one is high, grant it.
- **LD_A:**
  - `req_ready[grant]`=1; all other `req_ready` bits are 0.
  - `mul_data` = `req_data[grant]`.
  - `mul_load_a` = `req_valid[grant]`.
  - On `req_valid[grant]` the beat is accepted; go to LD_B. Otherwise hold.
- **LD_B:** same as LD_A, using `mul_load_b`; on accept go to WAIT.
- **WAIT:** exactly one cycle, during which the multiplier output register captures A*B; go to RES.
- **RES:**
  - `res_valid`=1, `res_product` = `mul_product`, `res_id` = `grant`.
  - On `res_valid && res_ready`: `last_grant` <= `grant`, `op_count` += 1, go to IDLE.
- **Outputs outside the states named above:**
  - `mul_data` = 0, both load strobes = 0, `req_ready` = 0.
  - `res_valid` = 0; `res_product` and `res_id` = 0 outside RES.
- **Operand stability:** no load strobe is asserted in WAIT or RES, so the multiplier's A/B and product stay stable during result back-pressure.
- **Arithmetic:** unsigned, full 2N-bit product, no truncation. Worst case is (2^N-1)^2.
- **Mid-beat requests:** a requester deasserting `req_valid` between its A and B beats stalls the scheduler in LD_B. There is no timeout, and the other requester is not served meanwhile.
- **Reset (`clr` low), any state, asynchronous:**
  - state <= IDLE, `grant` <= 0, `last_grant` <= 1 (requester 0 wins the first tie), `op_count` <= 0.
  - All outputs are 0.

## Timing
- Cycle 0 = first IDLE cycle with a valid request; zero-wait requesters assumed.
  - Cycle 1: LD_A.
  - Cycle 2: LD_B.
  - Cycle 3: WAIT.
  - Cycle 4: RES with `res_valid`=1.
- Minimum 5 cycles per operation; no overlap between operations.
- `req_ready`, `mul_*`, `res_valid`, `res_product` and `res_id` are combinational from the state registers and `req_valid`. They have no path from `res_ready`.
- `op_count` updates on the edge that completes the result handshake.
- A request arriving in the same cycle the scheduler returns to IDLE is granted at the next IDLE evaluation. Round-robin uses the updated `last_grant`.

## Test plan
- **Single operation:** req0 supplies A=13, B=11 with `res_ready`=1 -> `res_valid` in cycle 4, `res_product`=143, `res_id`=0, `op_count`=1, `mul_load_a` in cycle 1, `mul_load_b` in cycle 2.
- **Worst-case product:** req1 supplies A=255, B=255 -> `res_product`=16'hFE01, `res_id`=1.
- **Fairness:** both requesters valid continuously from reset with distinct operands (req0: 3,5; req1: 7,9) -> results alternate 15(id0), 63(id1), 15(id0), 63(id1); `op_count`=4.
- **Back-pressure:** `res_ready` low for 3 cycles in RES -> `res_valid` and `res_product` held stable, `mul_load_*` and `req_ready` stay 0, `op_count` does not increment until the accept.
- **Mid-operation reset:**
  - `clr` pulsed low while in LD_B -> all outputs 0 immediately, `op_count`=0, `busy`=0.
  - Afterwards both requesters valid -> req0 is granted first.
- **Counter wrap and stall:**
  - With `CNT_W`=2, 4 accepted results -> `op_count` wraps to 0.
  - req0 drops `req_valid` for 2 cycles between beats -> scheduler holds in LD_B and the product is still correct.
